// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
//   Run/stop and configuration controller for a programmable clock divider.
//   Owns the divide ratio and the phase counter and produces a registered,
//   glitch-free O_CLK (low half first) plus a one-cycle tick at the rising
//   edge. Generation is continuous or limited to a burst of whole periods.
//   Ratio updates while running are held in a shadow register and take
//   effect only on a period boundary.
module clk_div_ctrl #(
  parameter int CNT_W       = 32,
  parameter int DIV_DEFAULT = 20,
  parameter int BURST_W     = 16
) (
  input  logic               I_CLK,
  input  logic               rst,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   cfg_div,
  output logic               cfg_ready,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  input  logic [BURST_W-1:0] burst_len,
  output logic               O_CLK,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cur_div
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [CNT_W-1:0]   p;
  logic [CNT_W-1:0]   p_nxt;
  logic [CNT_W-1:0]   div_nxt;
  logic [CNT_W-1:0]   shadow;
  logic [CNT_W-1:0]   shadow_nxt;
  logic               pending;
  logic               pending_nxt;
  logic [BURST_W-1:0] rem;
  logic [BURST_W-1:0] rem_nxt;

  logic               o_clk_nxt;
  logic               tick_nxt;
  logic               done_nxt;
  logic               err_nxt;

  logic               hs;
  logic               hs_ok;
  logic               hs_bad;
  logic               at_bnd;
  logic               burst_last;
  logic               leaving;
  logic               running_nxt;

  // Rising-edge phase of a period: floor(div/2), so odd ratios get the
  // longer high half.
  function automatic logic [CNT_W-1:0] half_of(input logic [CNT_W-1:0] d);
    return d >> 1;
  endfunction

  // A ratio below 2 cannot produce both a low and a high half.
  function automatic logic ratio_ok(input logic [CNT_W-1:0] d);
    return d >= CNT_W'(2);
  endfunction

  assign cfg_ready = ~pending;
  assign busy      = (state != IDLE);

  assign hs     = cfg_valid & cfg_ready;
  assign hs_ok  = hs & ratio_ok(cfg_div);
  assign hs_bad = hs & ~ratio_ok(cfg_div);

  // The >= keeps p bounded even if the ratio were ever to shrink mid-period.
  assign at_bnd = (state != IDLE) && (p >= (cur_div - CNT_W'(1)));

  // rem is zero in continuous mode, so only a live burst can hit its last period.
  assign burst_last = (rem == BURST_W'(1));

  // State register
  always_ff @(posedge I_CLK) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a stop on the boundary itself and a burst end on the
  // same boundary both collapse into a single return to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (at_bnd && (stop || burst_last)) state_nxt = IDLE;
        else if (stop)                      state_nxt = DRAIN;
      end
      DRAIN: begin
        if (at_bnd) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign leaving     = (state != IDLE) && (state_nxt == IDLE);
  assign running_nxt = (state_nxt != IDLE);

  // Output / datapath next values: phase, burst count, ratio handling and
  // the registered O_CLK/tick computed from the phase and ratio they will
  // accompany, so the waveform stays aligned with p.
  always_comb begin
    p_nxt       = p;
    rem_nxt     = rem;
    div_nxt     = cur_div;
    shadow_nxt  = shadow;
    pending_nxt = pending;
    err_nxt     = hs_bad;
    done_nxt    = leaving;

    if (state == IDLE || state_nxt == IDLE || at_bnd) begin
      p_nxt = '0;
    end else begin
      p_nxt = p + CNT_W'(1);
    end

    if (state == IDLE) begin
      if (start) rem_nxt = burst_len;
    end else if (at_bnd && (rem != '0)) begin
      rem_nxt = rem - BURST_W'(1);
    end

    if (state == IDLE) begin
      if (hs_ok) div_nxt = cfg_div;
    end else begin
      if (hs_ok) begin
        shadow_nxt  = cfg_div;
        pending_nxt = 1'b1;
      end
      if (leaving) begin
        // Nothing may stay pending in IDLE, including a ratio accepted on
        // the very cycle generation ends.
        if (hs_ok)        div_nxt = cfg_div;
        else if (pending) div_nxt = shadow;
        pending_nxt = 1'b0;
      end else if (at_bnd && pending) begin
        div_nxt     = shadow;
        pending_nxt = 1'b0;
      end
    end

    o_clk_nxt = running_nxt && (p_nxt >= half_of(div_nxt));
    tick_nxt  = running_nxt && (p_nxt == half_of(div_nxt));
  end

  // Datapath and output registers; the shadow value needs no reset because
  // it is only consumed while pending is set.
  always_ff @(posedge I_CLK) begin
    shadow <= shadow_nxt;
    if (!rst) begin
      p       <= '0;
      rem     <= '0;
      cur_div <= CNT_W'(DIV_DEFAULT);
      pending <= 1'b0;
      O_CLK   <= 1'b0;
      tick    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      p       <= p_nxt;
      rem     <= rem_nxt;
      cur_div <= div_nxt;
      pending <= pending_nxt;
      O_CLK   <= o_clk_nxt;
      tick    <= tick_nxt;
      done    <= done_nxt;
      cfg_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl
//   Directed bench for clk_div_ctrl with hand-computed waveform expectations.
module tb_clk_div_ctrl;

  localparam int CNT_W   = 32;
  localparam int BURST_W = 16;

  logic               I_CLK;
  logic               rst;
  logic               cfg_valid;
  logic [CNT_W-1:0]   cfg_div;
  logic               cfg_ready;
  logic               cfg_err;
  logic               start;
  logic               stop;
  logic [BURST_W-1:0] burst_len;
  logic               O_CLK;
  logic               tick;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   cur_div;

  int n_checks;
  int n_errors;

  clk_div_ctrl #(
    .CNT_W      (CNT_W),
    .DIV_DEFAULT(20),
    .BURST_W    (BURST_W)
  ) dut (
    .I_CLK    (I_CLK),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .start    (start),
    .stop     (stop),
    .burst_len(burst_len),
    .O_CLK    (O_CLK),
    .tick     (tick),
    .busy     (busy),
    .done     (done),
    .cur_div  (cur_div)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance n clocks and land 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge I_CLK);
    #1;
  endtask

  // Checks O_CLK and tick for ncyc cycles starting at phase 0 of a period.
  task automatic run_wave(input string tag, input int div, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      chk_val({tag, "_oclk"}, 64'(O_CLK), 64'(((i % div) >= (div / 2)) ? 1 : 0));
      chk_val({tag, "_tick"}, 64'(tick),  64'(((i % div) == (div / 2)) ? 1 : 0));
      step(1);
    end
  endtask

  int hi_cnt;
  int dn_cnt;
  int dn_k;
  int tk_cnt;
  int idle_k;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    start     = 1'b0;
    stop      = 1'b0;
    burst_len = '0;
    step(2);

    // Reset state
    chk_val("rst_oclk",  64'(O_CLK),     64'd0);
    chk_val("rst_tick",  64'(tick),      64'd0);
    chk_val("rst_busy",  64'(busy),      64'd0);
    chk_val("rst_done",  64'(done),      64'd0);
    chk_val("rst_err",   64'(cfg_err),   64'd0);
    chk_val("rst_ready", 64'(cfg_ready), 64'd1);
    chk_val("rst_div",   64'(cur_div),   64'd20);
    rst = 1'b1;
    step(1);

    // Continuous run at the default ratio: low 10 / high 10
    start = 1'b1;
    burst_len = '0;
    step(1);
    start = 1'b0;
    chk_val("t1_busy", 64'(busy),    64'd1);
    chk_val("t1_div",  64'(cur_div), 64'd20);
    run_wave("t1", 20, 40);

    // Ratio change to 8 offered at p=5; current period stays 20
    step(5);
    chk_val("t3_ready_pre", 64'(cfg_ready), 64'd1);
    cfg_valid = 1'b1;
    cfg_div   = 32'd8;
    step(1);
    cfg_valid = 1'b0;
    chk_val("t3_div_hold", 64'(cur_div), 64'd20);
    for (int i = 6; i < 20; i++) begin
      chk_val("t3_ready_low", 64'(cfg_ready), 64'd0);
      chk_val("t3_oclk20",    64'(O_CLK),     64'((i >= 10) ? 1 : 0));
      step(1);
    end
    chk_val("t3_div_new",   64'(cur_div),   64'd8);
    chk_val("t3_ready_new", 64'(cfg_ready), 64'd1);
    run_wave("t3", 8, 16);

    // Ratio 1 while running is rejected; start while running is ignored
    cfg_valid = 1'b1;
    cfg_div   = 32'd1;
    step(1);
    cfg_valid = 1'b0;
    chk_val("t5_err",   64'(cfg_err),   64'd1);
    chk_val("t5_div",   64'(cur_div),   64'd8);
    chk_val("t5_ready", 64'(cfg_ready), 64'd1);
    start     = 1'b1;
    burst_len = 16'd1;
    step(1);
    start = 1'b0;
    chk_val("t5_err_clr", 64'(cfg_err), 64'd0);
    step(2);
    chk_val("t5_nostart_oclk", 64'(O_CLK), 64'd1);
    chk_val("t5_nostart_tick", 64'(tick),  64'd1);

    // Go back to ratio 20 at p=4, applied at the boundary after p=7
    cfg_valid = 1'b1;
    cfg_div   = 32'd20;
    step(1);
    cfg_valid = 1'b0;
    chk_val("t4_pend", 64'(cfg_ready), 64'd0);
    step(3);
    chk_val("t4_div20", 64'(cur_div),   64'd20);
    chk_val("t4_rdy20", 64'(cfg_ready), 64'd1);

    // Stop at p=3 of a 20-cycle period: drain p=4..19 then IDLE
    step(3);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk_val("t4_drain_busy", 64'(busy), 64'd1);
    hi_cnt = 0;
    dn_cnt = 0;
    idle_k = -1;
    for (int k = 0; k < 30; k++) begin
      if (O_CLK) hi_cnt++;
      if (done) dn_cnt++;
      if (!busy && idle_k < 0) idle_k = k;
      step(1);
    end
    chk_val("t4_high",   64'(hi_cnt), 64'd10);
    chk_val("t4_done",   64'(dn_cnt), 64'd1);
    chk_val("t4_idle_k", 64'(idle_k), 64'd16);
    chk_val("t4_oclk0",  64'(O_CLK),  64'd0);

    // Ratio 7 in IDLE, burst of 3: low 3 / high 4, done 21 cycles after entry
    cfg_valid = 1'b1;
    cfg_div   = 32'd7;
    step(1);
    cfg_valid = 1'b0;
    chk_val("t2_div7", 64'(cur_div), 64'd7);
    start     = 1'b1;
    burst_len = 16'd3;
    step(1);
    start = 1'b0;
    dn_cnt = 0;
    dn_k   = -1;
    tk_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (k < 21) chk_val("t2_oclk", 64'(O_CLK), 64'(((k % 7) >= 3) ? 1 : 0));
      if (done) begin
        dn_cnt++;
        dn_k = k;
      end
      if (tick) tk_cnt++;
      step(1);
    end
    chk_val("t2_done_cnt", 64'(dn_cnt), 64'd1);
    chk_val("t2_done_k",   64'(dn_k),   64'd21);
    chk_val("t2_ticks",    64'(tk_cnt), 64'd3);
    chk_val("t2_busy",     64'(busy),   64'd0);

    // Burst of 2 at ratio 7 with stop on the final boundary: one done
    start     = 1'b1;
    burst_len = 16'd2;
    step(1);
    start = 1'b0;
    step(13);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk_val("t5b_done_now", 64'(done), 64'd1);
    chk_val("t5b_idle",     64'(busy), 64'd0);
    dn_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) dn_cnt++;
      step(1);
    end
    chk_val("t5b_done_cnt", 64'(dn_cnt), 64'd1);

    // Reset during the high half with a ratio change pending
    start     = 1'b1;
    burst_len = '0;
    step(1);
    start = 1'b0;
    step(1);
    cfg_valid = 1'b1;
    cfg_div   = 32'd9;
    step(1);
    cfg_valid = 1'b0;
    chk_val("t6_pend", 64'(cfg_ready), 64'd0);
    step(2);
    chk_val("t6_high", 64'(O_CLK), 64'd1);
    rst = 1'b0;
    step(1);
    chk_val("t6_oclk",  64'(O_CLK),     64'd0);
    chk_val("t6_busy",  64'(busy),      64'd0);
    chk_val("t6_div",   64'(cur_div),   64'd20);
    chk_val("t6_ready", 64'(cfg_ready), 64'd1);
    chk_val("t6_done",  64'(done),      64'd0);
    rst = 1'b1;
    step(1);
    chk_val("t6_done_after", 64'(done), 64'd0);
    chk_val("t6_idle_after", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
